// File: rtl/mfcc_framer.sv
// Overlapping-frame buffer for the MFCC front end: circular sample RAM, framed
// valid/ready output stream, per-frame energy and energy-threshold VAD flag.
module mfcc_framer #(
    parameter int DATA_W    = 16,
    parameter int FRAME_LEN = 256,
    parameter int HOP       = 128,
    parameter int IDX_W     = 8,
    parameter int EN_W      = 2*DATA_W+IDX_W,
    parameter logic [EN_W-1:0] VAD_THRESH = EN_W'(1000000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] x_i,
    input  logic              write,
    input  logic              out_ready,
    output logic [DATA_W-1:0] x_o,
    output logic [IDX_W-1:0]  out_index,
    output logic              dv_out,
    output logic              frame_done,
    output logic [EN_W-1:0]   energy_o,
    output logic              vad,
    output logic              overrun
);

    localparam int BUF_DEPTH = 2*FRAME_LEN;
    localparam int PTR_W     = IDX_W+1;
    localparam int AV_W      = IDX_W+2;

    localparam logic [AV_W-1:0]  AV_FRAME  = AV_W'(FRAME_LEN);
    localparam logic [AV_W-1:0]  AV_FULL   = AV_W'(BUF_DEPTH);
    localparam logic [AV_W-1:0]  AV_HOP    = AV_W'(HOP);
    localparam logic [AV_W-1:0]  AV_ONE    = AV_W'(1);
    localparam logic [PTR_W-1:0] PTR_HOP   = PTR_W'(HOP);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0] FETCH_ALL = PTR_W'(FRAME_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(FRAME_LEN-1);

    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  base_q, base_d;
    logic [PTR_W-1:0]  fetch_cnt_q, fetch_cnt_d;
    logic [AV_W-1:0]   avail_q, avail_d;
    logic [EN_W-1:0]   acc_q, acc_d;
    logic [EN_W-1:0]   energy_q, energy_d;
    logic [IDX_W-1:0]  out_index_q, out_index_d;
    logic              dv_q, dv_d;
    logic              frame_done_q, frame_done_d;
    logic              vad_q, vad_d;
    logic              overrun_q, overrun_d;
    logic [DATA_W-1:0] x_o_q;

    logic [DATA_W-1:0] mem [BUF_DEPTH];

    logic                     wr_acc, xfer, rd_en, start;
    logic signed [2*DATA_W-1:0] sq;
    logic [EN_W-1:0]          sq_ext;

    assign sq     = $signed(x_o_q) * $signed(x_o_q);
    assign sq_ext = EN_W'($unsigned(sq));

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        base_d       = base_q;
        fetch_cnt_d  = fetch_cnt_q;
        avail_d      = avail_q;
        acc_d        = acc_q;
        energy_d     = energy_q;
        out_index_d  = out_index_q;
        dv_d         = dv_q;
        frame_done_d = 1'b0;
        vad_d        = vad_q;
        overrun_d    = overrun_q;
        start        = 1'b0;

        wr_acc = write && (avail_q != AV_FULL);
        xfer   = dv_q && out_ready;
        // The output register can take a new sample when empty or being drained.
        rd_en  = (state_q == EMIT) && (fetch_cnt_q != FETCH_ALL) && (!dv_q || out_ready);

        if (write && !wr_acc) overrun_d = 1'b1;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            avail_d  = avail_q + AV_ONE;
        end

        if (rd_en) begin
            rd_ptr_d    = rd_ptr_q + PTR_ONE;
            fetch_cnt_d = fetch_cnt_q + PTR_ONE;
            out_index_d = fetch_cnt_q[IDX_W-1:0];
            dv_d        = 1'b1;
        end else if (xfer) begin
            dv_d = 1'b0;
        end
        if (xfer) acc_d = acc_q + sq_ext;

        case (state_q)
            IDLE: if (avail_q >= AV_FRAME) start = 1'b1;
            EMIT: if (xfer && out_index_q == IDX_LAST) begin
                state_d      = DONE;
                frame_done_d = 1'b1;
            end
            DONE: begin
                base_d   = base_q + PTR_HOP;
                avail_d  = avail_d - AV_HOP;
                energy_d = acc_q;
                vad_d    = acc_q > VAD_THRESH;
                if (avail_d >= AV_FRAME) start = 1'b1;
                else                     state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            state_d     = EMIT;
            rd_ptr_d    = base_d;
            fetch_cnt_d = '0;
            acc_d       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr_q] <= x_i;
    end

    // Synchronous RAM read port doubles as the x_o output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        x_o_q <= '0;
        else if (rd_en) x_o_q <= mem[rd_ptr_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            base_q       <= '0;
            fetch_cnt_q  <= '0;
            avail_q      <= '0;
            acc_q        <= '0;
            energy_q     <= '0;
            out_index_q  <= '0;
            dv_q         <= 1'b0;
            frame_done_q <= 1'b0;
            vad_q        <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            base_q       <= base_d;
            fetch_cnt_q  <= fetch_cnt_d;
            avail_q      <= avail_d;
            acc_q        <= acc_d;
            energy_q     <= energy_d;
            out_index_q  <= out_index_d;
            dv_q         <= dv_d;
            frame_done_q <= frame_done_d;
            vad_q        <= vad_d;
            overrun_q    <= overrun_d;
        end
    end

    assign x_o        = x_o_q;
    assign out_index  = out_index_q;
    assign dv_out     = dv_q;
    assign frame_done = frame_done_q;
    assign energy_o   = energy_q;
    assign vad        = vad_q;
    assign overrun    = overrun_q;

endmodule
